burst_mem_responder: RTL and testbench
======================================

// Module: burst_mem_responder
// PURPOSE
//   Responder end of the 64-bit burst memory protocol that the cacheline adaptor drives.
//   Accepts one line-sized read or write request and transfers it as 4 beats of 64 bits.
//   Backing store is an internal line array with a programmable access latency.
//   Used as a synthesizable memory stand-in and as the reference responder for adaptor and
//   cache-hierarchy benches.
// PARAMETERS
//   DEPTH_LOG2  8   log2 of the number of 256-bit lines stored
//   LATENCY     10  cycles from request acceptance to the first beat; must be >= 1
// PORTS
//   clk          in   1   clock; all logic on posedge
//   rst          in   1   synchronous, active-high reset
//   burst_read   in   1   read request; held high by the initiator until the burst completes
//   burst_write  in   1   write request; held high by the initiator until the burst completes
//   burst_addr   in   32  byte address; bits [4:0] ignored, line index = addr[5 +: DEPTH_LOG2]
//   burst_wdata  in   64  write beat; the initiator advances it after each resp cycle
//   burst_rdata  out  64  read beat; valid only while burst_resp is high during a read
//   burst_resp   out  1   beat strobe; high for exactly 4 consecutive cycles per transaction
//   busy         out  1   high in every state except IDLE
//   proto_err    out  1   sticky protocol-violation flag; cleared only by rst
// BEHAVIOUR
//   - Reset: state=IDLE; burst_resp=0, burst_rdata=0, busy=0, proto_err=0; counters cleared.
//     The line array is NOT reset and keeps its contents. Reset mid-burst aborts immediately:
//     remaining beats are never issued, and write beats already committed stay committed.
//   - States: IDLE -> WAIT -> BURST -> DONE -> IDLE.
//   - IDLE: on an edge with exactly one of read/write high, latch op, line index and
//     lat_cnt=LATENCY-1, then go to WAIT. Both high: set proto_err, accept nothing, stay IDLE.
//   - WAIT: decrement lat_cnt; at 0 go to BURST with beat=0. The first resp is high in the
//     cycle starting LATENCY edges after the accepting edge (LATENCY=1 gives the next cycle).
//   - BURST: burst_resp=1 for beats 0..3. Each beat k covers bits [64k+63:64k] of the line.
//     Read: burst_rdata = line[k], registered and aligned with resp. Write: burst_wdata is
//     sampled and committed to line[k] on the edge that ends the resp cycle for beat k.
//     After beat 3, go to DONE.
//   - DONE: resp=0. Stay until burst_read=0 and burst_write=0, then go to IDLE. This stops a
//     held request from retriggering. Earliest back-to-back gap is 1 idle cycle.
//   - Address and op are latched at acceptance; changes during WAIT/BURST are ignored.
//   - If the request drops during WAIT or BURST, the burst still completes and proto_err is
//     set. If the op flips (read<->write) mid-transaction, proto_err is set and the latched op
//     is used.
//   - burst_rdata=0 whenever burst_resp=0 or the op is a write.
//   - Line-index wrap: addresses above the array size alias modulo 2^DEPTH_LOG2 lines,
//     with no error.
//   - Beat counter is 2 bits; the latency counter width is $clog2(LATENCY+1).
// STRUCTURE
//   - burst_pkg: BEAT_W=64, BEATS=4, LINE_W=256, typedef enum {IDLE,WAIT,BURST,DONE}
//     burst_state_t, typedef enum {OP_READ,OP_WRITE} burst_op_t.
//   - Sub-module burst_line_ram: 2^DEPTH_LOG2 x 4 x 64 storage, one 64-bit beat port
//     (index, beat, we, wdata, rdata). Reads are registered with 1-cycle latency, so the
//     controller issues each read beat one cycle ahead.
//   - Top level holds the FSM, latch registers, counters and error logic.
// TESTING
//   1 Read after reset, LATENCY=3: line 2 = {64'hD,C,B,A}; read addr 32'h40, edge E0 ->
//     resp high for cycles E0+3..E0+6 with rdata A,B,C,D, then resp=0 and busy=0 once read drops.
//   2 Write then read: write addr 32'h60 with beats 1,2,3,4, advancing wdata per resp ->
//     a read of 32'h7F (offset ignored) returns 1,2,3,4.
//   3 Held request: keep burst_read high for 20 cycles after beat 3 -> exactly 4 resp pulses,
//     FSM stays in DONE, no second burst.
//   4 Read and write both high in IDLE -> proto_err=1, resp never asserted, busy=0.
//     Dropping read during WAIT -> 4 beats still issued and proto_err=1.
//   5 rst asserted during write beat 2 -> next cycle resp=0, busy=0, proto_err=0. Reading the
//     line back returns the new beats 0-1 and the old beats 2-3.
//   6 Wrap: DEPTH_LOG2=8; write addr 32'h2000 (index 256) -> a read of 32'h0 returns the
//     same data.

Source files
------------

// File: rtl/burst_pkg.sv
// Shared types and widths for the 64-bit burst memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package burst_pkg;

  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;
  localparam int LINE_W = BEAT_W * BEATS;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } burst_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } burst_op_t;

endpackage

// File: rtl/burst_line_ram.sv
// Line store: 2^DEPTH_LOG2 lines of BEATS x BEAT_W, one beat-wide port.
// Latency: read data registered, valid 1 cycle after index/beat; writes commit on the edge.
// Backpressure: none; accepts one access every cycle.
//
// Ports:
//   clk    - clock
//   index  - line index
//   beat   - beat within the line
//   we     - write enable for the addressed beat
//   wdata  - beat write data
//   rdata  - registered beat read data (old contents on a same-cycle write)
module burst_line_ram
  import burst_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                       clk,
  input  logic [DEPTH_LOG2-1:0]      index,
  input  logic [$clog2(BEATS)-1:0]   beat,
  input  logic                       we,
  input  logic [BEAT_W-1:0]          wdata,
  output logic [BEAT_W-1:0]          rdata
);

  localparam int WORDS = (2 ** DEPTH_LOG2) * BEATS;

  // Contents are deliberately not reset so they survive rst.
  logic [BEAT_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{index, beat}] <= wdata;
    end
    rdata <= mem[{index, beat}];
  end

endmodule

// File: rtl/burst_mem_responder.sv
// Responder for the 64-bit burst memory protocol: one 256-bit line per request, 4 beats.
// Latency: first burst_resp LATENCY cycles after the accepting edge, then 4 back-to-back beats.
// Backpressure: none on beats; a held request parks in DONE until both read and write drop.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   burst_read   - read request, held until the burst completes
//   burst_write  - write request, held until the burst completes
//   burst_addr   - byte address; line index = addr[5 +: DEPTH_LOG2]
//   burst_wdata  - write beat, advanced by the initiator after each resp cycle
//   burst_rdata  - read beat, zero unless a read beat is being strobed
//   burst_resp   - beat strobe, high for 4 consecutive cycles per transaction
//   busy         - high whenever the FSM is not IDLE
//   proto_err    - sticky protocol-violation flag, cleared only by rst
module burst_mem_responder
  import burst_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              burst_read,
  input  logic              burst_write,
  input  logic [31:0]       burst_addr,
  input  logic [BEAT_W-1:0] burst_wdata,
  output logic [BEAT_W-1:0] burst_rdata,
  output logic              burst_resp,
  output logic              busy,
  output logic              proto_err
);

  localparam int LAT_W  = $clog2(LATENCY + 1);
  localparam int BEAT_IW = $clog2(BEATS);

  burst_state_t            state, state_nxt;
  burst_op_t               op_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [LAT_W-1:0]        lat_cnt;
  logic [BEAT_IW-1:0]      beat;

  logic                    accept;
  logic                    err_set;
  logic                    req_held;

  logic [BEAT_IW-1:0]      ram_beat;
  logic                    ram_we;
  logic [BEAT_W-1:0]       ram_rdata;

  // Offset bits and address bits above the array are intentionally dropped (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{burst_addr[4:0], burst_addr[31:5+DEPTH_LOG2]};

  // The request for the latched op must stay up, alone, for the whole transaction.
  assign req_held = (op_q == OP_READ) ? (burst_read && !burst_write)
                                      : (burst_write && !burst_read);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (burst_read && burst_write) begin
          err_set = 1'b1;
        end else if (burst_read || burst_write) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!req_held) err_set = 1'b1;
        if (lat_cnt == '0) state_nxt = BURST;
      end
      BURST: begin
        if (!req_held) err_set = 1'b1;
        if (beat == BEAT_IW'(BEATS - 1)) state_nxt = DONE;
      end
      DONE: begin
        if (!burst_read && !burst_write) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_READ;
      idx_q     <= '0;
      lat_cnt   <= '0;
      beat      <= '0;
      proto_err <= 1'b0;
    end else begin
      if (err_set) proto_err <= 1'b1;
      if (accept) begin
        op_q    <= burst_write ? OP_WRITE : OP_READ;
        idx_q   <= burst_addr[5 +: DEPTH_LOG2];
        lat_cnt <= LAT_W'(LATENCY - 1);
        beat    <= '0;
      end
      if (state == WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - LAT_W'(1);
      if (state == BURST) beat <= beat + BEAT_IW'(1);
    end
  end

  // The RAM read is registered, so read beats are addressed one cycle early: beat 0 during
  // the last WAIT cycle (beat is still 0 there), beat k+1 while beat k is on the bus.
  assign ram_beat = (state == BURST && op_q == OP_READ) ? beat + BEAT_IW'(1) : beat;
  // A beat in flight when rst arrives is not committed.
  assign ram_we   = (state == BURST) && (op_q == OP_WRITE) && !rst;

  burst_line_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .index(idx_q),
    .beat (ram_beat),
    .we   (ram_we),
    .wdata(burst_wdata),
    .rdata(ram_rdata)
  );

  assign burst_resp  = (state == BURST);
  assign busy        = (state != IDLE);
  assign burst_rdata = (burst_resp && op_q == OP_READ) ? ram_rdata : '0;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder (DEPTH_LOG2=8, LATENCY=3).
// Latency: first resp expected 3 cycles after the accepting edge.
// Backpressure: requests held through the DONE cycle, then dropped.
module tb_burst_mem_responder;
  import burst_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              burst_read;
  logic              burst_write;
  logic [31:0]       burst_addr;
  logic [BEAT_W-1:0] burst_wdata;
  logic [BEAT_W-1:0] burst_rdata;
  logic              burst_resp;
  logic              busy;
  logic              proto_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  burst_mem_responder #(
    .DEPTH_LOG2(8),
    .LATENCY   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .burst_read (burst_read),
    .burst_write(burst_write),
    .burst_addr (burst_addr),
    .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata),
    .burst_resp (burst_resp),
    .busy       (busy),
    .proto_err  (proto_err)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction starting at a negedge. first_c = resp cycle index relative to the
  // accepting edge; quiet = rdata was zero whenever it had to be.
  task automatic run_burst(input bit is_wr, input logic [31:0] addr, input logic [LINE_W-1:0] wline,
                           input int hold, output logic [LINE_W-1:0] rline, output int first_c,
                           output int pulses, output bit consec, output bit quiet,
                           output logic busy_hold, output logic busy_end);
    int c;
    int last_c;
    rline   = '0;
    first_c = -1;
    pulses  = 0;
    consec  = 1'b1;
    quiet   = 1'b1;
    last_c  = -1;
    c       = 0;
    burst_addr  = addr;
    burst_read  = !is_wr;
    burst_write = is_wr;
    burst_wdata = wline[63:0];
    while (pulses < 4 && c < 100) begin
      @(negedge clk);
      c++;
      if ((!burst_resp || is_wr) && burst_rdata !== '0) quiet = 1'b0;
      if (burst_resp) begin
        if (first_c < 0) first_c = c - 1;
        if (last_c >= 0 && c != last_c + 1) consec = 1'b0;
        last_c = c;
        if (!is_wr) rline[pulses*64 +: 64] = burst_rdata;
        else        burst_wdata = wline[pulses*64 +: 64];
        pulses++;
      end
    end
    // DONE cycle plus any extra hold with the request still up.
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      if (burst_resp) pulses++;
      if (burst_rdata !== '0) quiet = 1'b0;
    end
    busy_hold   = busy;
    burst_read  = 1'b0;
    burst_write = 1'b0;
    @(negedge clk);
    busy_end = busy;
  endtask

  logic [LINE_W-1:0] line2, line3, old4, new4, wrapd, rline;
  int    first_c, pulses, cnt, bz;
  bit    consec, quiet;
  logic  busy_hold, busy_end;

  initial begin
    line2 = {64'hD, 64'hC, 64'hB, 64'hA};
    line3 = {64'h4, 64'h3, 64'h2, 64'h1};
    old4  = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
             64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    new4  = {64'hF4F4, 64'hF3F3, 64'hF2F2, 64'hF1F1};
    wrapd = {64'hCAFE_0003, 64'hCAFE_0002, 64'hCAFE_0001, 64'hCAFE_0000};

    rst = 1'b1; burst_read = 1'b0; burst_write = 1'b0; burst_addr = '0; burst_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_resp", 256'(burst_resp), 256'(0));
    check("reset_busy", 256'(busy), 256'(0));
    check("reset_err", 256'(proto_err), 256'(0));
    check("reset_rdata", 256'(burst_rdata), 256'(0));
    rst = 1'b0;

    // Preload line 2, then reset: contents must survive rst.
    run_burst(1'b1, 32'h40, line2, 0, rline, first_c, pulses, consec, quiet, busy_hold, busy_end);
    check("pre_wr_pulses", 256'(pulses), 256'(4));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // 1: read after reset, LATENCY=3.
    run_burst(1'b0, 32'h40, '0, 0, rline, first_c, pulses, consec, quiet, busy_hold, busy_end);
    check("t1_rdata", rline, line2);
    check("t1_first_lat", 256'(first_c), 256'(3));
    check("t1_pulses", 256'(pulses), 256'(4));
    check("t1_consec", 256'(consec), 256'(1));
    check("t1_rdata_quiet", 256'(quiet), 256'(1));
    check("t1_busy_done", 256'(busy_hold), 256'(1));
    check("t1_busy_end", 256'(busy_end), 256'(0));

    // 2: write then read with offset bits set.
    run_burst(1'b1, 32'h60, line3, 0, rline, first_c, pulses, consec, quiet, busy_hold, busy_end);
    check("t2_wr_first_lat", 256'(first_c), 256'(3));
    check("t2_wr_quiet", 256'(quiet), 256'(1));
    run_burst(1'b0, 32'h7F, '0, 0, rline, first_c, pulses, consec, quiet, busy_hold, busy_end);
    check("t2_rdata", rline, line3);

    // 3: request held 20 cycles past beat 3.
    run_burst(1'b0, 32'h60, '0, 20, rline, first_c, pulses, consec, quiet, busy_hold, busy_end);
    check("t3_pulses", 256'(pulses), 256'(4));
    check("t3_busy_held", 256'(busy_hold), 256'(1));
    check("t3_busy_end", 256'(busy_end), 256'(0));
    check("t3_no_err", 256'(proto_err), 256'(0));

    // 4a: read and write both high in IDLE.
    burst_addr = 32'h40; burst_read = 1'b1; burst_write = 1'b1;
    cnt = 0; bz = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (burst_resp) cnt++;
      if (busy) bz++;
    end
    burst_read = 1'b0; burst_write = 1'b0;
    @(negedge clk);
    check("t4_both_resp", 256'(cnt), 256'(0));
    check("t4_both_busy", 256'(bz), 256'(0));
    check("t4_both_err", 256'(proto_err), 256'(1));

    // 4b: read dropped during WAIT still gives 4 beats and flags the error.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_err_cleared", 256'(proto_err), 256'(0));
    burst_addr = 32'h40; burst_read = 1'b1;
    @(negedge clk);
    burst_read = 1'b0;
    cnt = 0; rline = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (burst_resp) begin
        if (cnt < 4) rline[cnt*64 +: 64] = burst_rdata;
        cnt++;
      end
    end
    check("t4_drop_pulses", 256'(cnt), 256'(4));
    check("t4_drop_rdata", rline, line2);
    check("t4_drop_err", 256'(proto_err), 256'(1));
    check("t4_drop_busy", 256'(busy), 256'(0));

    // 5: reset during write beat 2.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_burst(1'b1, 32'h80, old4, 0, rline, first_c, pulses, consec, quiet, busy_hold, busy_end);
    burst_addr = 32'h80; burst_write = 1'b1; burst_wdata = new4[63:0];
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 3; i++) begin
      @(negedge clk);
      if (burst_resp) begin
        if (cnt == 2) rst = 1'b1;
        else burst_wdata = new4[cnt*64 +: 64];
        cnt++;
      end
    end
    check("t5_reached_beat2", 256'(cnt), 256'(3));
    @(negedge clk);
    check("t5_resp", 256'(burst_resp), 256'(0));
    check("t5_busy", 256'(busy), 256'(0));
    check("t5_err", 256'(proto_err), 256'(0));
    rst = 1'b0; burst_write = 1'b0;
    @(negedge clk);
    run_burst(1'b0, 32'h80, '0, 0, rline, first_c, pulses, consec, quiet, busy_hold, busy_end);
    check("t5_rdata", rline, {old4[255:128], new4[127:0]});

    // 6: index 256 aliases onto index 0.
    run_burst(1'b1, 32'h2000, wrapd, 0, rline, first_c, pulses, consec, quiet, busy_hold, busy_end);
    run_burst(1'b0, 32'h0, '0, 0, rline, first_c, pulses, consec, quiet, busy_hold, busy_end);
    check("t6_wrap_rdata", rline, wrapd);
    check("t6_no_err", 256'(proto_err), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
